// File: rtl/mvu_out_buf_pkg.sv
// Shared MVAU stream-path definitions: lane geometry, result word type and
// the width helper used for occupancy counters and pointers.
package mvu_out_buf_pkg;

    localparam int PE     = 2;
    localparam int TDstI  = 16;
    localparam int WORD_W = PE * TDstI;

    // Packed accumulator vector; PE0 occupies the least significant lane.
    typedef logic [WORD_W-1:0] result_t;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mvu_out_buf_if.sv
// AXI-Stream result channel between the MVU output buffer and its consumer.
interface mvu_out_buf_if;
    import mvu_out_buf_pkg::*;

    result_t tdata;
    logic    tvalid;
    logic    tlast;
    logic    tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/mvu_out_fifo.sv
// Circular result buffer behind the output register; pointers wrap modulo
// ENTRIES, which need not be a power of two. No knowledge of AXI.
module mvu_out_fifo
    import mvu_out_buf_pkg::*;
#(
    parameter int ENTRIES = 7
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  result_t din,
    output result_t head,
    output logic    empty,
    output logic    full
);

    localparam int PW = width_for(ENTRIES - 1);
    localparam int CW = width_for(ENTRIES);
    localparam logic [PW-1:0] PTR_LAST = PW'(ENTRIES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(ENTRIES);

    result_t       mem [ENTRIES];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the storage array is deliberately not reset; pointers and count
    // alone define which entries are valid, so the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // NOTE: all state uses non-blocking assignments so every read in this
    // cycle sees pre-edge values, including push and pop on a full buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

endmodule

// File: rtl/mvu_out_buf.sv
// MVU output stage: captures accumulator result vectors, buffers them and
// streams them out on AXI-Stream with per-vector tlast and an almost-full stall.
module mvu_out_buf
    import mvu_out_buf_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 4,
    parameter int NF        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_v,
    input  result_t          in_dat,
    mvu_out_buf_if.master    m_axis,
    output logic             out_stall,
    output logic             ovf_err
);

    localparam int CW = width_for(DEPTH);
    localparam int WW = width_for(NF - 1);
    localparam logic [CW-1:0] AF_LEVEL  = CW'(DEPTH - AF_MARGIN);
    localparam logic [WW-1:0] WCNT_LAST = WW'(NF - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [WW-1:0] wcnt;
    logic          pop;
    logic          push_acc;
    logic          out_free;
    logic          load;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    result_t       fifo_head;

    mvu_out_fifo #(.ENTRIES(DEPTH - 1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_dat),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Every slot is occupied exactly when the FIFO is full behind a valid
    // output register; a same-cycle pop still frees room for the new word.
    always_comb begin
        pop       = m_axis.tvalid && m_axis.tready;
        push_acc  = in_v && (!(fifo_full && m_axis.tvalid) || pop);
        out_free  = !m_axis.tvalid || pop;
        load      = out_free && (!fifo_empty || push_acc);
        fifo_pop  = out_free && !fifo_empty;
        fifo_push = push_acc && !(out_free && fifo_empty);
        cnt_next  = cnt + CW'(push_acc) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            wcnt          <= '0;
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            out_stall     <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            out_stall <= (cnt_next >= AF_LEVEL);
            if (in_v && !push_acc)
                ovf_err <= 1'b1;
            // Words are tagged for framing as they enter the output register.
            if (load) begin
                m_axis.tdata  <= fifo_empty ? in_dat : fifo_head;
                m_axis.tvalid <= 1'b1;
                m_axis.tlast  <= (wcnt == WCNT_LAST);
                wcnt          <= (wcnt == WCNT_LAST) ? '0 : wcnt + 1'b1;
            end else if (pop) begin
                m_axis.tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mvu_out_buf.sv
// Self-checking bench for mvu_out_buf: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_mvu_out_buf;
    import mvu_out_buf_pkg::*;

    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 4;
    localparam int NF        = 3;

    logic    clk    = 1'b0;
    logic    rst_n  = 1'b0;
    logic    in_v   = 1'b0;
    result_t in_dat = '0;
    logic    out_stall;
    logic    ovf_err;

    mvu_out_buf_if m_axis ();

    mvu_out_buf #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .NF(NF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_v      (in_v),
        .in_dat    (in_dat),
        .m_axis    (m_axis),
        .out_stall (out_stall),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        result_t data;
        logic    last;
    } entry_t;

    // Model: every occupied slot in arrival order, head = output register.
    entry_t q[$];
    int     tag;
    bit     m_stall;
    bit     m_ovf;
    bit     model_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit     pop;
        bit     acc;
        entry_t e;
        if (!rst_n) begin
            q.delete();
            tag         = 0;
            m_stall     = 1'b0;
            m_ovf       = 1'b0;
            model_ready = 1'b1;
            return;
        end
        if (!model_ready)
            return;
        pop = (q.size() != 0) && m_axis.tready;
        acc = in_v && ((q.size() < DEPTH) || pop);
        if (in_v && !acc)
            m_ovf = 1'b1;
        if (pop)
            void'(q.pop_front());
        if (acc) begin
            e.data = in_dat;
            e.last = (tag == NF - 1);
            q.push_back(e);
            tag = (tag + 1) % NF;
        end
        m_stall = (q.size() >= DEPTH - AF_MARGIN);
    endtask

    task automatic compare();
        check("tvalid", 64'(m_axis.tvalid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("tdata", 64'(m_axis.tdata), 64'(q[0].data));
            check("tlast", 64'(m_axis.tlast), 64'(q[0].last));
        end
        check("out_stall", 64'(out_stall), 64'(m_stall));
        check("ovf_err", 64'(ovf_err), 64'(m_ovf));
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (model_ready)
            compare();
    end

    task automatic step(input logic v, input result_t d, input logic r);
        in_v          = v;
        in_dat        = d;
        m_axis.tready = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int bias;
        m_axis.tready = 1'b0;
        do_reset();
        check("reset_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("reset_tdata", 64'(m_axis.tdata), 64'd0);
        check("reset_stall", 64'(out_stall), 64'd0);
        check("reset_ovf", 64'(ovf_err), 64'd0);

        // Single result, one-cycle latency, then the register empties.
        step(1'b1, 32'h0003_0005, 1'b1);
        check("single_tvalid", 64'(m_axis.tvalid), 64'd1);
        check("single_tdata", 64'(m_axis.tdata), 64'h0003_0005);
        check("single_tlast", 64'(m_axis.tlast), 64'd0);
        step(1'b0, '0, 1'b1);
        check("single_drop", 64'(m_axis.tvalid), 64'd0);

        // Framing over two vectors.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, result_t'(i * 32'h11), 1'b1);
            check("frame_tdata", 64'(m_axis.tdata), 64'(i * 32'h11));
            check("frame_tlast", 64'(m_axis.tlast), 64'(i % 3 == 0));
        end
        step(1'b0, '0, 1'b1);
        check("frame_idle", 64'(m_axis.tvalid), 64'd0);

        // Backpressure fill to DEPTH, then one overflowing push.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, result_t'(i), 1'b0);
            check("fill_head", 64'(m_axis.tdata), 64'd1);
            check("fill_stall", 64'(out_stall), 64'(i >= 4));
        end
        check("fill_ovf", 64'(ovf_err), 64'd0);
        step(1'b1, result_t'(9), 1'b0);
        check("ovf_set", 64'(ovf_err), 64'd1);
        step(1'b0, '0, 1'b0);
        check("ovf_sticky", 64'(ovf_err), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_tdata", 64'(m_axis.tdata), 64'(i));
            check("drain_tlast", 64'(m_axis.tlast), 64'(i % 3 == 0));
            step(1'b0, '0, 1'b1);
        end
        check("drain_empty", 64'(m_axis.tvalid), 64'd0);
        check("drain_ovf", 64'(ovf_err), 64'd1);

        // Full buffer: simultaneous push and pop must both succeed.
        do_reset();
        for (int i = 1; i <= 8; i++)
            step(1'b1, result_t'(32'h100 + i), 1'b0);
        step(1'b1, result_t'(32'h1FF), 1'b1);
        check("full_pp_ovf", 64'(ovf_err), 64'd0);
        check("full_pp_head", 64'(m_axis.tdata), 64'h102);
        step(1'b1, result_t'(32'h1EE), 1'b0);
        check("full_still_full", 64'(ovf_err), 64'd1);

        // Reset with five words buffered and ovf_err set.
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b1);
        check("mid_stall", 64'(out_stall), 64'd1);
        do_reset();
        check("mid_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("mid_stall_clr", 64'(out_stall), 64'd0);
        check("mid_ovf_clr", 64'(ovf_err), 64'd0);
        step(1'b1, result_t'(32'hABCD), 1'b1);
        check("mid_new_tdata", 64'(m_axis.tdata), 64'hABCD);
        check("mid_new_tlast", 64'(m_axis.tlast), 64'd0);

        // Random traffic with varying backpressure and occasional resets.
        bias = 5;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0)
                bias = $urandom_range(1, 9);
            rst_n = ($urandom_range(0, 499) != 0);
            step($urandom_range(0, 9) < 6, result_t'($urandom), $urandom_range(0, 9) < bias);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++)
            step(1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
